// File: rtl/cpu_pkg.sv
// Shared definitions for the iterative divider slice.
//   DIV_WIDTH          default operand/result width
//   div_state_t        divider FSM encoding (IDLE, RUN, FIX, DONE)
//   DIV_ZERO_QUOTIENT  quotient reported for a zero divisor (all ones)
package cpu_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } div_state_t;

  localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOTIENT = '1;

endpackage

// File: rtl/seq_divider_if.sv
// Request/result bundle between the control unit and the sequential divider.
//   start        request pulse (control -> divider)
//   dividend     signed dividend (control -> divider)
//   divisor      signed divisor (control -> divider)
//   busy         operation in progress (divider -> control)
//   done         one-cycle completion pulse (divider -> control)
//   quotient     signed quotient, LO mux source (divider -> datapath)
//   remainder    signed remainder, HI mux source (divider -> datapath)
//   div_by_zero  last operation had a zero divisor (divider -> control)
interface seq_divider_if
  import cpu_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) ();

  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/seq_divider_div_step.sv
// One restoring-division iteration (purely combinational).
//   p       current partial remainder, WIDTH+1 bits
//   q       current quotient shift register
//   d       unsigned divisor magnitude
//   p_next  partial remainder after shift and trial subtract
//   q_next  quotient register with the new bit shifted in
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   p,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH:0]   p_next,
  output logic [WIDTH-1:0] q_next
);

  // Worked one bit wider than P so the borrow of the trial subtract is the
  // top bit of the difference; P < D always holds, so nothing is lost.
  logic [WIDTH+1:0] p_shift;
  logic [WIDTH+1:0] trial;

  always_comb begin
    p_shift = {p, q[WIDTH-1]};
    trial   = p_shift - {2'b00, d};
    if (trial[WIDTH+1]) begin
      p_next = p_shift[WIDTH:0];
      q_next = {q[WIDTH-2:0], 1'b0};
    end else begin
      p_next = trial[WIDTH:0];
      q_next = {q[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Iterative signed divider, restoring algorithm, one quotient bit per clock.
//   clk  system clock, rising edge
//   clr  synchronous active-high reset, overrides everything
//   bus  seq_divider_if slave: start/dividend/divisor in;
//        busy/done/quotient/remainder/div_by_zero out
// Magnitudes are divided unsigned and the signs are applied in FIX:
// quotient truncates toward zero, remainder follows the dividend's sign.
module seq_divider
  import cpu_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic         clk,
  input  logic         clr,
  seq_divider_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH);

  div_state_t       state_reg, state_next;
  logic [WIDTH:0]   p_reg, p_next, p_step;
  logic [WIDTH-1:0] q_reg, q_next, q_step;
  logic [WIDTH-1:0] d_reg, d_next;
  logic [WIDTH-1:0] dvd_reg, dvd_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             sign_q_reg, sign_q_next;
  logic             sign_r_reg, sign_r_next;
  logic             zero_reg, zero_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;
  logic             dbz_reg, dbz_next;
  logic [WIDTH-1:0] quot_reg, quot_next;
  logic [WIDTH-1:0] rem_reg, rem_next;

  div_step #(.WIDTH(WIDTH)) u_step (
    .p      (p_reg),
    .q      (q_reg),
    .d      (d_reg),
    .p_next (p_step),
    .q_next (q_step)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      state_reg  <= ST_IDLE;
      p_reg      <= '0;
      q_reg      <= '0;
      d_reg      <= '0;
      dvd_reg    <= '0;
      cnt_reg    <= '0;
      sign_q_reg <= 1'b0;
      sign_r_reg <= 1'b0;
      zero_reg   <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      dbz_reg    <= 1'b0;
      quot_reg   <= '0;
      rem_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      p_reg      <= p_next;
      q_reg      <= q_next;
      d_reg      <= d_next;
      dvd_reg    <= dvd_next;
      cnt_reg    <= cnt_next;
      sign_q_reg <= sign_q_next;
      sign_r_reg <= sign_r_next;
      zero_reg   <= zero_next;
      busy_reg   <= busy_next;
      done_reg   <= done_next;
      dbz_reg    <= dbz_next;
      quot_reg   <= quot_next;
      rem_reg    <= rem_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    p_next      = p_reg;
    q_next      = q_reg;
    d_next      = d_reg;
    dvd_next    = dvd_reg;
    cnt_next    = cnt_reg;
    sign_q_next = sign_q_reg;
    sign_r_next = sign_r_reg;
    zero_next   = zero_reg;
    busy_next   = busy_reg;
    done_next   = 1'b0;
    dbz_next    = dbz_reg;
    quot_next   = quot_reg;
    rem_next    = rem_reg;

    case (state_reg)
      ST_IDLE: begin
        if (bus.start) begin
          // Negating the most negative value yields 2^(WIDTH-1), which is
          // exactly its magnitude when read as unsigned.
          q_next      = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
          d_next      = bus.divisor[WIDTH-1] ? -bus.divisor : bus.divisor;
          p_next      = '0;
          dvd_next    = bus.dividend;
          sign_q_next = bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
          sign_r_next = bus.dividend[WIDTH-1];
          zero_next   = (bus.divisor == '0);
          cnt_next    = '0;
          busy_next   = 1'b1;
          state_next  = (bus.divisor == '0) ? ST_FIX : ST_RUN;
        end
      end
      ST_RUN: begin
        p_next   = p_step;
        q_next   = q_step;
        cnt_next = cnt_reg + CNT_W'(1);
        if (cnt_reg == CNT_W'(WIDTH - 1)) begin
          state_next = ST_FIX;
        end
      end
      ST_FIX: begin
        if (zero_reg) begin
          quot_next = {WIDTH{DIV_ZERO_QUOTIENT[0]}};
          rem_next  = dvd_reg;
        end else begin
          // A zero magnitude negates to zero, so no negative zero appears.
          quot_next = sign_q_reg ? -q_reg : q_reg;
          rem_next  = sign_r_reg ? -p_reg[WIDTH-1:0] : p_reg[WIDTH-1:0];
        end
        dbz_next   = zero_reg;
        done_next  = 1'b1;
        state_next = ST_DONE;
      end
      ST_DONE: begin
        busy_next  = 1'b0;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign bus.busy        = busy_reg;
  assign bus.done        = done_reg;
  assign bus.quotient    = quot_reg;
  assign bus.remainder   = rem_reg;
  assign bus.div_by_zero = dbz_reg;

endmodule
